// File: rtl/ysyx_22040386_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22040386_pkg
// Brief   : Shared encodings for the sequential divider (ops, FSM, width).
// Revision: 1.0 - initial release
// ============================================================================
package ysyx_22040386_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040386_div_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22040386_div_seq_if
// Brief   : Request/response handshake bundle between issue logic and divider.
// Revision: 1.0 - initial release
// ============================================================================
interface ysyx_22040386_div_seq_if #(
    parameter int WIDTH = ysyx_22040386_pkg::DIV_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output in_valid, op, dividend, divisor, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, dividend, divisor, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22040386_div_step.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22040386_div_step
// Brief   : One restoring-division iteration: shift, trial subtract, q bit.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_22040386_div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH:0]   i_rem,
    input  wire logic             i_dvd_bit,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic      [WIDTH:0]   o_rem,
    output logic                  o_q_bit
);
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_unused_msb;

    // The partial remainder is always below the divisor, so its MSB is zero.
    assign w_unused_msb = i_rem[WIDTH];
    assign w_shift      = {i_rem[WIDTH-1:0], i_dvd_bit};
    // Extra guard bit keeps the borrow of the trial subtract.
    assign w_diff       = {1'b0, w_shift} - {2'b00, i_divisor};
    assign o_q_bit      = ~w_diff[WIDTH+1];
    assign o_rem        = o_q_bit ? w_diff[WIDTH:0] : w_shift;
endmodule
`default_nettype wire

// File: rtl/ysyx_22040386_div_seq.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22040386_div_seq
// Brief   : Multi-cycle restoring divider (div/divu/rem/remu), one bit/cycle.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_22040386_div_seq
    import ysyx_22040386_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    ysyx_22040386_div_seq_if.slave      bus
);
    localparam int              CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    div_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_result;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_is_rem;
    logic             r_in_rdy;
    logic             r_out_valid;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_accept;
    logic [WIDTH:0]   w_rem_nxt;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_quot_fin;
    logic [WIDTH-1:0] w_rem_fin;

    assign w_signed   = op_is_signed(bus.op);
    assign w_a_neg    = w_signed & bus.dividend[WIDTH-1];
    assign w_b_neg    = w_signed & bus.divisor[WIDTH-1];
    assign w_a_abs    = w_a_neg ? -bus.dividend : bus.dividend;
    assign w_b_abs    = w_b_neg ? -bus.divisor  : bus.divisor;
    assign w_div_zero = (bus.divisor == '0);
    assign w_ovf      = w_signed && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                                 && (bus.divisor == '1);
    assign w_accept   = bus.in_valid && bus.in_ready;

    ysyx_22040386_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_dvd_bit (r_quot[WIDTH-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_nxt),
        .o_q_bit   (w_q_bit)
    );

    assign w_quot_fin = r_neg_q ? -r_quot : r_quot;
    assign w_rem_fin  = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    // Readiness is a register so it stays low through reset and the first edge after it.
    assign bus.in_ready  = r_in_rdy & ~bus.flush;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_dvs       <= '0;
            r_result    <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_is_rem    <= 1'b0;
            r_in_rdy    <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_in_rdy    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_rdy <= 1'b1;
                    if (w_accept) begin
                        r_in_rdy <= 1'b0;
                        r_is_rem <= op_is_rem(bus.op);
                        r_cnt    <= '0;
                        if (w_div_zero) begin
                            r_quot  <= '1;
                            r_rem   <= {1'b0, bus.dividend};
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= ST_DONE;
                        end else if (w_ovf) begin
                            r_quot  <= bus.dividend;
                            r_rem   <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_quot  <= w_a_abs;
                            r_rem   <= '0;
                            r_dvs   <= w_b_abs;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    // Dividend bits shift out of r_quot as quotient bits shift in.
                    r_rem  <= w_rem_nxt;
                    r_quot <= {r_quot[WIDTH-2:0], w_q_bit};
                    if (r_cnt == C_LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle applies sign correction and raises out_valid.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_result    <= r_is_rem ? w_rem_fin : w_quot_fin;
                    end else if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b0;
                        r_result    <= '0;
                        r_in_rdy    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040386_div_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_22040386_div_seq
// Brief   : Directed self-checking bench for the sequential divider.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ysyx_22040386_div_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ysyx_22040386_div_seq_if #(.WIDTH(32)) bus ();

    ysyx_22040386_div_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "/ov_clr"}, {31'b0, bus.out_valid}, 32'd0);
        check({tag, "/res_clr"}, bus.result, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        bus.op       = o;
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        check({tag, "/in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/result"}, bus.result, exp);
        consume(tag);
    endtask

    initial begin
        int lat;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst/out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst/result",    bus.result, 32'd0);
        check("rst/busy",      {31'b0, bus.busy}, 32'd0);
        check("rst/in_ready",  {31'b0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Normal-path arithmetic
        run_op("div100_7",   2'b00, 32'd100,      32'd7,        32'd14,       33);
        run_op("rem100_7",   2'b10, 32'd100,      32'd7,        32'd2,        33);
        run_op("rem-7_2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        run_op("div-7_2",    2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        run_op("divuFF_2",   2'b01, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 33);
        run_op("div100_-7",  2'b00, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33);
        run_op("remuFF_10",  2'b11, 32'hFFFFFFFF, 32'd10,       32'd5,        33);

        // Divide by zero and signed overflow shortcut paths
        run_op("divu5_0",    2'b01, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("rem5_0",     2'b10, 32'd5,        32'd0,        32'd5,        1);
        run_op("div_ovf",    2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // Hold in DONE with out_ready low; a pending request must not slip in
        @(negedge clk);
        bus.op = 2'b00; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("stall/latency", 32'(lat), 32'd33);
        bus.op = 2'b01; bus.dividend = 32'd9; bus.divisor = 32'd3; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall/out_valid", {31'b0, bus.out_valid}, 32'd1);
            check("stall/result",    bus.result, 32'd14);
            check("stall/in_ready",  {31'b0, bus.in_ready}, 32'd0);
        end
        @(negedge clk);
        check("stall/in_ready_consume", {31'b0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("stall/no_bypass_busy", {31'b0, bus.busy}, 32'd0);
        check("stall/out_valid_clr",  {31'b0, bus.out_valid}, 32'd0);
        check("stall/in_ready_after", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Flush at CALC iteration 10, asserted together with a new request
        @(negedge clk);
        bus.op = 2'b00; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        check("flush/busy_before", {31'b0, bus.busy}, 32'd1);
        check("flush/in_ready",    {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush/busy",      {31'b0, bus.busy}, 32'd0);
        check("flush/out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("flush/result",    bus.result, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("flush/idle_hold", {31'b0, bus.out_valid}, 32'd0);

        // Asynchronous reset pulse at CALC iteration 20
        @(negedge clk);
        bus.op = 2'b00; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstp/busy",      {31'b0, bus.busy}, 32'd0);
        check("rstp/in_ready",  {31'b0, bus.in_ready}, 32'd0);
        check("rstp/out_valid", {31'b0, bus.out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check("rstp/in_ready_rel", {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rstp/no_accept",   {31'b0, bus.busy}, 32'd0);
        check("rstp/ready_again", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("rstp/accepted", {31'b0, bus.busy}, 32'd1);
        wait_valid(lat);
        check("rstp/latency", 32'(lat), 32'd33);
        check("rstp/result",  bus.result, 32'd14);
        consume("rstp");

        run_op("post/div100_7", 2'b00, 32'd100, 32'd7, 32'd14, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
